// File: rtl/bird_uart_io.sv
// bird_uart_io: memory-mapped 8N1 UART for the bird CPU data bus.
// A four-register window at BASE: TXDATA, STATUS, RXDATA, RXACK.
// Stores to TXDATA are queued in a small TX FIFO and then serialised LSB first.
// Loads go through a combinational read mux. It returns 0 when the window is not selected.
// Optional receive path: define BIRD_UART_RX_EN to build it.
// Without that macro, rxd is ignored and the RX status bits and RXDATA read as 0.
module bird_uart_io #(
  parameter logic [15:0] BASE       = 16'h0FF0,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        memwt,
  output logic [15:0] rdata,
  output logic        sel,
  output logic        txd,
  input  logic        rxd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  // ---------------------------------------------------------------- bus decode
  logic wr_en;
  logic push_req;
  logic stat_wr;

  assign sel      = (addr[15:2] == BASE[15:2]);
  assign wr_en    = memwt & sel;
  assign push_req = wr_en & (addr[1:0] == 2'd0);
  assign stat_wr  = wr_en & (addr[1:0] == 2'd1);

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        tx_pop;
  logic        tx_drop_reg;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  // Fullness is judged before any same-cycle pop, so a push to a full FIFO is always lost.
  assign push       = push_req & ~fifo_full;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers and the sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      tx_drop_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tx_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_req && fifo_full) tx_drop_reg <= 1'b1;
      else if (stat_wr) tx_drop_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX serialiser
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  tx_state_t      tx_state_reg, tx_state_next;
  logic [CW-1:0]  tx_cnt_reg, tx_cnt_next;
  logic [2:0]     tx_bit_reg, tx_bit_next;
  logic [7:0]     tx_shift_reg, tx_shift_next;
  logic           txd_reg, txd_next;
  logic           tx_busy;

  assign tx_busy = (tx_state_reg != T_IDLE);
  assign txd     = txd_reg;

  // TX state register; the line output is registered so txd is glitch-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg <= T_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  // TX next-state: frame sequencing, and the line level that goes with the next state
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      T_IDLE: begin
        if (!fifo_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = fifo_mem[rd_ptr_reg[AW-1:0]];
          tx_cnt_next   = '0;
          tx_state_next = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_reg == DIV_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = T_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      T_DATA: begin
        if (tx_cnt_reg == DIV_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) tx_state_next = T_STOP;
          else                    tx_bit_next   = tx_bit_reg + 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: begin
        if (tx_cnt_reg == DIV_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = T_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
    endcase
    case (tx_state_next)
      T_START: txd_next = 1'b0;
      T_DATA:  txd_next = tx_shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic [7:0] rx_byte;

`ifdef BIRD_UART_RX_EN
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic          rx_done;
  logic          rx_ack;
  logic          rx_valid_reg, rx_overrun_reg, rx_frame_err_reg;
  logic [7:0]    rx_byte_reg;

  assign rx_ack       = wr_en & (addr[1:0] == 2'd3);
  assign rx_valid     = rx_valid_reg;
  assign rx_overrun   = rx_overrun_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_byte      = rx_byte_reg;

  // Two-stage synchroniser for the asynchronous line, plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rxd;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg <= R_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // RX next-state: re-check the start bit at mid-bit, then sample once per bit period
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_reg == DIV_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = R_STOP;
          else                    rx_bit_next   = rx_bit_reg + 1'b1;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_reg == DIV_LAST) begin
          rx_cnt_next   = '0;
          rx_done       = 1'b1;
          rx_state_next = R_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  // Receive holding register and sticky error flags. An ack on the delivery edge frees the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_byte_reg      <= '0;
    end else begin
      if (stat_wr) begin
        rx_overrun_reg   <= 1'b0;
        rx_frame_err_reg <= 1'b0;
      end
      if (rx_ack) rx_valid_reg <= 1'b0;
      if (rx_done) begin
        if (!rx_sync_reg) rx_frame_err_reg <= 1'b1;
        if (!rx_valid_reg || rx_ack) begin
          rx_byte_reg  <= rx_shift_reg;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_overrun_reg <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_rxd;
  assign unused_rxd   = rxd;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = 8'h00;
`endif

  // ---------------------------------------------------------------- read mux
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:8];

  // Combinational read-back; the CPU has no read strobe, so reads have no side effects
  always_comb begin
    rdata = 16'h0000;
    if (sel) begin
      case (addr[1:0])
        2'd1:    rdata = {9'b0, rx_frame_err, rx_overrun, rx_valid,
                          tx_drop_reg, tx_busy, fifo_empty, fifo_full};
        2'd2:    rdata = {8'b0, rx_byte};
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_uart_io.sv
// Testbench for bird_uart_io, using CLK_DIV=4, FIFO_DEPTH=4 and BASE=16'h0FF0.
// The stimulus process queues every byte it expects to see on the serial line.
// A separate monitor decodes each txd frame and checks it against that queue.
// RX checks follow the BIRD_UART_RX_EN build setting.
`timescale 1ns/1ps
module tb_bird_uart_io;
  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] BASE    = 16'h0FF0;
  localparam int          SPACING = 10 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        memwt = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] rdata;
  logic        sel;
  logic        txd;

  bird_uart_io #(.BASE(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .memwt(memwt),
    .rdata(rdata), .sel(sel), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // STATUS word built from the documented bit layout
  function automatic logic [15:0] status_of(input int occ, input bit busy, input bit drop,
                                            input bit rxv, input bit ovr, input bit ferr);
    logic [15:0] s;
    s = 16'h0000;
    s[0] = (occ == DEPTH);
    s[1] = (occ == 0);
    s[2] = busy;
    s[3] = drop;
    s[4] = rxv;
    s[5] = ovr;
    s[6] = ferr;
    return s;
  endfunction

  // Call at a negedge. The write lands on the next posedge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; memwt = 1'b1;
    @(negedge clk);
    memwt = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(name, {16'h0, rdata}, {16'h0, exp});
    addr = 16'h0000;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = stopb;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Monitor: decode frames on txd at mid-bit and score them against exp_q
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic       stopb;
    longint     t0;
    longint     last_t0;
    exp_t       e;
    prev    = 1'b1;
    last_t0 = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && prev && !txd) begin
        t0 = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (CLK_DIV) @(negedge clk);
        stopb = txd;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got frame 0x%02h, expected no frame", b);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'h0, b}, {24'h0, e.b});
          chk("tx_stop", {31'h0, stopb}, 32'h1);
          if (e.b2b) chk("tx_spacing", 32'(t0 - last_t0), SPACING);
        end
        last_t0 = t0;
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] bytes [6];
    int         len;
    int         occ;
    int         lows;
    bit         exp_bit;
    logic [7:0] tb;
    exp_t       e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_txd", {31'h0, txd}, 32'h1);
    rd_chk("reset_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Address decode
    for (int i = 0; i < 4; i++) begin
      addr = BASE + 16'(i);
      #1;
      chk("sel_in_window", {31'h0, sel}, 32'h1);
      @(negedge clk);
    end
    rd_chk("txdata_reads_0", BASE, 16'h0000);
    rd_chk("rxack_reads_0", BASE + 16'd3, 16'h0000);

    // Single frame 0xA5, checked cycle by cycle
    tb = 8'hA5;
    e.b = tb; e.b2b = 1'b0;
    exp_q.push_back(e);
    wr(BASE, 16'h00A5);
    chk("tx_still_idle_edge_n", {31'h0, txd}, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= CLK_DIV)           exp_bit = 1'b0;
      else if (k <= 9 * CLK_DIV)  exp_bit = tb[(k - CLK_DIV - 1) / CLK_DIV];
      else                        exp_bit = 1'b1;
      chk($sformatf("a5_txd_c%0d", k), {31'h0, txd}, {31'h0, exp_bit});
    end
    drain("a5_drain");
    rd_chk("a5_status_after", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));

    // Six back-to-back writes: 01 goes out at once, 02..05 queue up, 06 is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH + 1) begin
        e.b = 8'(i); e.b2b = (i > 1);
        exp_q.push_back(e);
      end
      wr(BASE, 16'(i));
    end
    rd_chk("burst6_status", BASE + 16'd1, status_of(DEPTH, 1, 1, 0, 0, 0));
    wr(BASE + 16'd1, 16'h0000);
    rd_chk("burst6_drop_cleared", BASE + 16'd1, status_of(DEPTH, 1, 0, 0, 0, 0));
    drain("burst6_drain");

    // Randomised bursts of 1..6 back-to-back writes, each started from idle
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < len; i++) begin
        if (i <= DEPTH) begin
          e.b = bytes[i]; e.b2b = (i > 0);
          exp_q.push_back(e);
        end
        wr(BASE, {8'h00, bytes[i]});
      end
      occ = (len == 1) ? 1 : ((len - 1 > DEPTH) ? DEPTH : len - 1);
      rd_chk($sformatf("rand%0d_len%0d_status", r, len), BASE + 16'd1,
             status_of(occ, len >= 2, len > DEPTH + 1, 0, 0, 0));
      wr(BASE + 16'd1, 16'h0000);
      drain($sformatf("rand%0d_drain", r));
    end

    // Out-of-window write must not touch the FIFO
    addr = BASE + 16'd4; wdata = 16'h0055; memwt = 1'b1;
    #1;
    chk("oow_sel", {31'h0, sel}, 32'h0);
    chk("oow_rdata", {16'h0, rdata}, 32'h0);
    @(negedge clk);
    memwt = 1'b0; addr = 16'h0000;
    repeat (60) @(negedge clk);
    rd_chk("oow_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));

    // Reset mid-frame with two bytes queued: the frame aborts and nothing else is sent
    mon_en = 1'b0;
    wr(BASE, 16'h00C3);
    wr(BASE, 16'h0011);
    wr(BASE, 16'h0022);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_txd", {31'h0, txd}, 32'h1);
    rd_chk("rst_mid_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("rst_mid_no_frames", lows, 0);
    mon_en = 1'b1;

`ifdef BIRD_UART_RX_EN
    send_rx(8'h3C, 1'b1);
    rd_chk("rx1_status", BASE + 16'd1, status_of(0, 0, 0, 1, 0, 0));
    rd_chk("rx1_data", BASE + 16'd2, 16'h003C);
    send_rx(8'h5A, 1'b1);
    rd_chk("rx_overrun_status", BASE + 16'd1, status_of(0, 0, 0, 1, 1, 0));
    rd_chk("rx_overrun_data", BASE + 16'd2, 16'h003C);
    wr(BASE + 16'd3, 16'h0000);
    rd_chk("rx_ack_status", BASE + 16'd1, status_of(0, 0, 0, 0, 1, 0));
    wr(BASE + 16'd1, 16'h0000);
    rd_chk("rx_clear_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    rd_chk("rx_false_start", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
    send_rx(8'h81, 1'b0);
    rd_chk("rx_ferr_status", BASE + 16'd1, status_of(0, 0, 0, 1, 0, 1));
    rd_chk("rx_ferr_data", BASE + 16'd2, 16'h0081);
    wr(BASE + 16'd3, 16'h0000);
    wr(BASE + 16'd1, 16'h0000);
    rd_chk("rx_final_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
`else
    send_rx(8'h3C, 1'b1);
    rd_chk("norx_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
    rd_chk("norx_data", BASE + 16'd2, 16'h0000);
    wr(BASE + 16'd3, 16'h0000);
    rd_chk("norx_ack_status", BASE + 16'd1, status_of(0, 0, 0, 0, 0, 0));
`endif

    // One last frame after all of the above, to show the transmitter still works
    e.b = 8'h96; e.b2b = 1'b0;
    exp_q.push_back(e);
    wr(BASE, 16'h0096);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
